// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decoded operands/control from ID, detects load-use hazards,
// inserts bubbles on hazard or branch flush, bypasses same-cycle WB writes
// into the captured operands, and keeps saturating stall/flush counters.

// Saturating up-counter used for the performance-monitor events.
module id_ex_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic at_max;

    assign at_max = &count;

    // Count one event per cycle, stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && !at_max)
            count <= count + 1'b1;
    end
endmodule

module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    // ID side
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_address,
    input  logic [4:0]      id_rs2_address,
    input  logic [4:0]      id_rd_address,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    // WB write port, bypassed into operands captured this cycle
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_address,
    input  logic [XLEN-1:0] wb_write_data,
    // pipeline control
    input  logic            ex_flush,
    input  logic            ext_stall,
    output logic            load_use_stall,
    // EX side
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_address,
    output logic [4:0]      ex_rs2_address,
    output logic [4:0]      ex_rd_address,
    output logic [3:0]      ex_alu_op,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    // performance counters
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Everything EX sees, kept as one record so a bubble is simply all-zeros
    // and a hold is a single self-assignment.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_address;
        logic [4:0]      rs2_address;
        logic [4:0]      rd_address;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t ex_d;
    ex_regs_t id_pkt;

    logic            hazard;
    logic            rs1_match;
    logic            rs2_match;
    logic            bypass_rs1;
    logic            bypass_rs2;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            stall_event;
    logic            flush_event;

    // Load-use hazard: the load now in EX produces a register that the
    // instruction in ID reads. x0 never creates a dependency.
    always_comb begin
        rs1_match = (ex_q.rd_address == id_rs1_address);
        rs2_match = (ex_q.rd_address == id_rs2_address);
        hazard    = ex_q.valid && ex_q.mem_read && (ex_q.rd_address != 5'd0) &&
                    id_valid && (rs1_match || rs2_match);
    end

    // A taken branch kills the ID instruction anyway, so no need to hold IF/ID.
    assign load_use_stall = hazard && !ex_flush;

    // The regfile is written at the end of this cycle, so the value ID read
    // is stale when WB targets the same register; take the WB data instead.
    always_comb begin
        bypass_rs1 = wb_reg_write && (wb_rd_address != 5'd0) &&
                     (wb_rd_address == id_rs1_address);
        bypass_rs2 = wb_reg_write && (wb_rd_address != 5'd0) &&
                     (wb_rd_address == id_rs2_address);
        rs1_value  = bypass_rs1 ? wb_write_data : id_rs1_data;
        rs2_value  = bypass_rs2 ? wb_write_data : id_rs2_data;
    end

    // Assemble the record that would be loaded from ID this cycle.
    always_comb begin
        id_pkt             = '0;
        id_pkt.valid       = 1'b1;
        id_pkt.pc          = id_pc;
        id_pkt.rs1_address = id_rs1_address;
        id_pkt.rs2_address = id_rs2_address;
        id_pkt.rd_address  = id_rd_address;
        id_pkt.rs1_data    = rs1_value;
        id_pkt.rs2_data    = rs2_value;
        id_pkt.imm         = id_imm;
        id_pkt.alu_op      = id_alu_op;
        id_pkt.reg_write   = id_reg_write;
        id_pkt.mem_read    = id_mem_read;
        id_pkt.mem_write   = id_mem_write;
    end

    // Next-state selection: flush > external freeze > hazard bubble > load.
    // A bubble is all-zeros, which also clears the register addresses so the
    // forwarding unit never matches against it.
    always_comb begin
        ex_d = '0;
        if (ex_flush)
            ex_d = '0;
        else if (ext_stall)
            ex_d = ex_q;
        else if (hazard)
            ex_d = '0;
        else if (id_valid)
            ex_d = id_pkt;
        else
            ex_d = '0;
    end

    // Pipeline register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    // A stall event is a hazard bubble actually inserted this edge; a flush
    // event counts every flush cycle, even while MEM is frozen.
    always_comb begin
        stall_event = hazard && !ex_flush && !ext_stall;
        flush_event = ex_flush;
    end

    id_ex_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_event),
        .count (stall_count)
    );

    id_ex_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_event),
        .count (flush_count)
    );

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_rs1_address = ex_q.rs1_address;
    assign ex_rs2_address = ex_q.rs2_address;
    assign ex_rd_address  = ex_q.rd_address;
    assign ex_rs1_data    = ex_q.rs1_data;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;

endmodule
